// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_ctrl
// Description : Run controller for the 19-bit XOR-feedback LFSR. Sequences
//               sh_en for a fixed shift count or until the LFSR reports the
//               end of its period (max_tick), with a timeout guard. Counts
//               MSB ones/zeros and shifts, and exposes a start/busy/done
//               handshake to the host.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_seq_ctrl #(
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 524288
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             max_tick,
  input  logic             msb,
  output logic             sh_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] zeros_cnt,
  output logic [CNT_W-1:0] shifts
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] zeros_q, zeros_d;
  logic [CNT_W-1:0] shifts_q, shifts_d;
  logic             timeout_q, timeout_d;
  logic             sh_en_q, busy_q, done_q;
  logic [CNT_W-1:0] w_shifts_inc;

  // Shift count including the current RUN cycle; drives both the counter
  // update and the end-of-run compares so they agree on the same cycle.
  assign w_shifts_inc = shifts_q + C_ONE;

  // Next-state and counter update logic.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    ones_d    = ones_q;
    zeros_d   = zeros_q;
    shifts_d  = shifts_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode;
          len_d     = len;
          ones_d    = '0;
          zeros_d   = '0;
          shifts_d  = '0;
          timeout_d = 1'b0;
          // A zero-length fixed run skips RUN entirely and never shifts.
          if (!mode && (len == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Abort wins over every completion condition and leaves the
        // aborting cycle uncounted.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          shifts_d = w_shifts_inc;
          if (msb) begin
            ones_d = ones_q + C_ONE;
          end else begin
            zeros_d = zeros_q + C_ONE;
          end
          if (!mode_q) begin
            if (w_shifts_inc == len_q) begin
              state_d = ST_DONE;
            end
          end else if (max_tick) begin
            state_d = ST_DONE;
          end else if (w_shifts_inc == C_TIMEOUT) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched run parameters and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      len_q     <= '0;
      ones_q    <= '0;
      zeros_q   <= '0;
      shifts_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      ones_q    <= ones_d;
      zeros_q   <= zeros_d;
      shifts_q  <= shifts_d;
      timeout_q <= timeout_d;
    end
  end

  // Registered decode of the next state so handshake outputs are glitch-free
  // and line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sh_en_q <= (state_d == ST_RUN);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign sh_en     = sh_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign ones_cnt  = ones_q;
  assign zeros_cnt = zeros_q;
  assign shifts    = shifts_q;

endmodule
`default_nettype wire

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Run controller for the 19-bit XOR-feedback LFSR (`lfsr_mod`) and its MSB statistics path. It sequences `sh_en` for either a fixed number of shifts or one full sequence period, terminated by `max_tick`. It also counts the ones and zeros seen on the LFSR MSB. A start/busy/done handshake lets a host or test sequencer launch measurements without driving `sh_en` directly.

## Interface

**Parameters**
- `CNT_W`, default 20: width of the length field and all counters. Must hold 2^19−1.
- `TIMEOUT`, default 524288: maximum shifts in period mode before the run is forced to end.

**Ports**
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: launch request. Sampled only in IDLE.
- `mode`, in, 1: run mode, latched at start.
  - 0 = fixed length.
  - 1 = run until `max_tick`.
- `len`, in, `CNT_W`: shift count for mode 0, latched at start.
- `abort`, in, 1: cancel an active run.
- `max_tick`, in, 1: from the LFSR, high for the cycle the LFSR completes its period.
- `msb`, in, 1: LFSR MSB for the current cycle, before that cycle's shift.
- `sh_en`, out, 1: shift enable to the LFSR.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle pulse marking a completed run.
- `timeout`, out, 1: sticky flag. Cleared on the next accepted start.
- `ones_cnt`, out, `CNT_W`: MSB=1 samples in the last or current run.
- `zeros_cnt`, out, `CNT_W`: MSB=0 samples in the last or current run.
- `shifts`, out, `CNT_W`: `sh_en` cycles in the last or current run.

## Operation

- **States:** IDLE, RUN, DONE. The state register is cleared asynchronously to IDLE.
- **Reset values:** `sh_en`=0, `busy`=0, `done`=0, `timeout`=0, all counters 0.
- **IDLE**
  - `sh_en`=0.
  - If `start`=1, the block latches `mode` and `len`, clears the three counters and `timeout`, then:
    - mode 0 with `len`=0 → DONE (zero-length run, no shift).
    - otherwise → RUN.
- **RUN**
  - `sh_en`=1, driven as a registered decode of the state.
  - Each cycle: `shifts`+1, plus `ones_cnt`+1 if `msb`=1, else `zeros_cnt`+1.
  - Mode 0: the cycle in which `shifts`+1 == `len` is the last shift → DONE.
  - Mode 1: a cycle with `max_tick`=1 is counted and is the last shift → DONE.
  - Mode 1: if `shifts`+1 == `TIMEOUT` without `max_tick`, that cycle is counted, `timeout` is set, → DONE.
  - `abort`=1 → IDLE next cycle.
    - The aborting cycle is not counted and no `done` pulse is produced.
    - Counters hold their partial values.
    - `abort` has priority over the completion conditions in the same cycle.
- **DONE**
  - `done`=1 and `sh_en`=0 for one cycle, then → IDLE.
  - `start` is ignored in DONE and RUN; there is no queueing.
- **Counters**
  - Hold from run end until the next accepted start.
  - Never wrap, because `len` and `TIMEOUT` ≤ 2^`CNT_W`−1.
- **`abort` outside RUN:** ignored.
- **Asserting `rst_n` mid-run:** returns immediately to the reset values. The LFSR shares `rst_n`, so the two restart together.

## Timing

- `start` is sampled at edge 0. `sh_en` is high for cycles 1..L (L = shift count), `done` is high in cycle L+1, and `busy` is high in cycles 1..L+1.
- Zero-length run: `done` in cycle 1, `busy` for cycle 1 only, `sh_en` never asserted.
- Counters update on the edge ending each RUN cycle. They are final, and stable, in the cycle `done`=1.
- `msb` and `max_tick` are sampled in the same cycle as `sh_en`=1, with no added input latency.
- Earliest restart: `start` seen in the cycle after `done` → `sh_en` two cycles later.

## Test plan

- **Fixed length:** reset, mode 0, `len`=10.
  - `sh_en` high exactly in cycles 1..10, `done` in cycle 11.
  - `shifts`=10 and `ones_cnt`+`zeros_cnt`=10.
  - `ones_cnt` matches a reference model of the first 10 MSBs.
- **Full period:** fresh reset, mode 1, default parameters, real `lfsr_mod`.
  - `shifts`=524287, `ones_cnt`=262144, `zeros_cnt`=262143.
  - `timeout`=0, `done` one cycle after the `max_tick` cycle.
- **Zero length:** mode 0, `len`=0.
  - `done` in cycle 1, `sh_en` never 1, all counters 0.
- **Timeout:** `TIMEOUT`=16, `max_tick` tied 0, mode 1.
  - `shifts`=16, `timeout`=1, `done` in cycle 17.
  - The next start clears `timeout`.
- **Abort:** `len`=100, `abort` in cycle 40.
  - `shifts`=39, no `done`, `busy`=0 from cycle 41.
  - `start` asserted during cycles 1–39 has no effect.
- **Reset mid-run:** drop `rst_n` in cycle 25.
  - All outputs return to 0 asynchronously and stay IDLE after release.
